// File: rtl/load_store_unit.sv
// Load/store unit: turns a datapath memory instruction into one word-aligned
// req/ack memory transaction with byte enables, stalls the core while the
// access is in flight, and reports extended load data or an error code in a
// single-cycle completion beat.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  // Only the RV32 width codes this unit supports are accepted.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte-lane mask, shared by loads and stores.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Next-state and next-output logic for the IDLE/REQ/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    rdata_d     = 32'd0;
    err_d       = 1'b0;
    err_code_d  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (!f3_legal(i_is_store, i_funct3)) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if (misaligned(i_funct3, i_addr[1:0])) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d     = S_REQ;
            cnt_d       = 8'd0;
            f3_d        = i_funct3;
            lo_d        = i_addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = i_is_store;
            mem_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = lane_be(i_funct3, i_addr[1:0]);
            mem_wdata_d = i_is_store ? store_data(i_funct3, i_wdata) : 32'd0;
          end
        end
      end
      S_REQ: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (i_mem_ack || (cnt_q == TO_LAST)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'd0;
          mem_wdata_d = 32'd0;
          cnt_d       = 8'd0;
          if (i_mem_ack) begin
            rdata_d = mem_we_q ? 32'd0 : load_ext(f3_q, lo_q, i_mem_rdata);
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and all registered outputs; reset drops the request at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      f3_q        <= 3'd0;
      lo_q        <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Stall covers the accepting IDLE cycle and every REQ cycle, never DONE.
  assign o_stall = !i_rst && ((state_q == S_REQ) || ((state_q == S_IDLE) && i_valid));

  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath (execute result) and the data memory port.
- Turns a load/store request into a word-aligned memory transaction with byte enables, using a req/ack handshake.
- Holds the core stalled while the transaction is in flight. Returns sign- or zero-extended load data, or an error code, in a one-cycle completion beat.
- Single-cycle core today; the same interface serves the planned MEM stage.

Parameters:
- TIMEOUT, 16, number of cycles in REQ without i_mem_ack before the access is aborted (legal range 1..255).
- ADDR_W, 32, width of i_addr and o_mem_addr.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  datapath presents a memory instruction this cycle.
- i_is_store  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32 width/sign code.
- i_addr  in  ADDR_W  effective byte address.
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  freeze PC and pipeline.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data, valid when o_done=1.
- o_err  out  1  error with o_done.
- o_err_code  out  2  01 misaligned, 10 timeout, 11 illegal funct3.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0).
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-placed store data.
- i_mem_ack  in  1  memory accepted/completed the request.
- i_mem_rdata  in  32  read word, valid with i_mem_ack.

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0. Asserting reset during REQ drops o_mem_req immediately (asynchronously), with no done pulse.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal (code 11).
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- State machine has three states: IDLE, REQ, DONE.
  - IDLE, i_valid=1, legal and aligned: latch request, go to REQ. o_stall=1 combinationally in this cycle.
  - IDLE, i_valid=1, illegal or misaligned: go to DONE with error latched. No memory request is ever issued. o_stall=1 this cycle.
  - REQ: o_mem_req=1, and o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata are registered and stable until ack. o_stall=1. The counter increments each cycle.
    - i_mem_ack=1: capture i_mem_rdata and go to DONE.
    - Counter reaches TIMEOUT-1 without ack: drop the request, go to DONE with code 10 and o_rdata=0.
    - If ack and timeout occur in the same cycle, ack wins.
  - DONE: o_done=1, o_stall=0, o_rdata/o_err/o_err_code valid for exactly this cycle, then return to IDLE.
    - A new i_valid in DONE is ignored; the datapath advances, so the next instruction is sampled in IDLE.
- Outside DONE, o_rdata, o_err and o_err_code are 0.
- i_mem_ack outside REQ is ignored.
- Latency: a zero-wait memory (ack in first REQ cycle) completes in 3 cycles (IDLE→REQ→DONE). The error path takes 2 cycles.
- Store lane placement:
  - SB: wdata byte replicated in all 4 lanes; be = 1<<addr[1:0].
  - SH: half replicated in both halves; be = 0011 if addr[1]=0, else 1100.
  - SW: be = 1111.
- Loads drive o_mem_be with the same lane mask as stores.
- Load extraction:
  - Byte selected by addr[1:0], half by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- o_mem_we=0 for all loads.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, ack in 1st REQ cycle → mem_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1. o_done in cycle 3; o_stall high cycles 1–2.
- LB addr 0x203, mem rdata 0x80AB_CD12 → be 1000; o_rdata 0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH addr 0x302, wdata 0x0000_1234 → mem_addr 0x300, be 1100, wdata 0x12341234. LH same address with rdata 0xF00D_0000 → o_rdata 0xFFFFF00D.
- LW addr 0x101 → no o_mem_req ever asserted; o_done with o_err=1, code 01, cycle 2. funct3=011 load → code 11.
- TIMEOUT=4, load with ack never asserted → o_mem_req high exactly 4 cycles, then o_done, code 10, o_rdata 0. Ack on the 4th cycle instead → normal completion.
- Assert i_rst in the 2nd REQ cycle → o_mem_req and o_stall drop before the next clock edge; no o_done. After release, a new SW completes normally.
